// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UartXmt transmitter between NREQ byte sources.
// Also generates the 1/DIV bit-clock enable and drives the Shift_LdF / XmitMT handshake.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DIV      = 16,
    parameter int EN_PHASE = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       reqData,
    output logic [NREQ-1:0]         ack,
    output logic                    enable,
    output logic                    shiftLoad,
    output logic [7:0]              parallelOut,
    input  logic                    txEmpty,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grantId
);

    // state | meaning
    // IDLE  | transmitter free; arbitrate when txEmpty=1 and any req
    // LOAD  | byte captured, Shift_LdF=0 until the next bit-clock enable
    // SEND  | frame shifting out; return to IDLE when txEmpty is seen

    localparam int IW = $clog2(NREQ);
    localparam int DW = $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t         state;
    logic [DW-1:0]  freq_div;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  winner;
    logic           win_found;

    // Free-running divider; DIV is a power of two so the wrap is natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            freq_div <= '0;
        end else begin
            freq_div <= freq_div + 1'b1;
        end
    end

    assign enable = (freq_div == DW'(EN_PHASE));
    assign busy   = (state != IDLE);

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req[(int'(rr_ptr) + k) % NREQ]) begin
                win_found = 1'b1;
                winner    = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ack         <= '0;
            shiftLoad   <= 1'b1;
            parallelOut <= 8'h00;
            grantId     <= '0;
            rr_ptr      <= IW'(NREQ - 1);
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    shiftLoad <= 1'b1;
                    if (txEmpty && win_found) begin
                        parallelOut <= reqData[8*winner +: 8];
                        grantId     <= winner;
                        rr_ptr      <= winner;
                        ack[winner] <= 1'b1;
                        shiftLoad   <= 1'b0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (enable) begin
                        shiftLoad <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (txEmpty) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    shiftLoad <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural UartXmt model on the transmit side
// and a round-robin reference model for predicting grants.
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int DIV      = 16;
    localparam int EN_PHASE = 7;
    localparam int IW       = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [8*NREQ-1:0]   reqData = '0;
    logic [NREQ-1:0]     ack;
    logic                enable;
    logic                shiftLoad;
    logic [7:0]          parallelOut;
    logic                txEmpty;
    logic                busy;
    logic [IW-1:0]       grantId;

    int errors = 0;
    int checks = 0;
    int ack_total = 0;
    int rr_model = NREQ - 1;

    logic       hold_low = 1'b0;
    logic       model_empty;
    logic       txd;
    logic [8:0] sh;
    int         cnt;
    int         line_q[$];

    always #5 clock = ~clock;

    assign txEmpty = model_empty & ~hold_low;

    uart_tx_arbiter #(.NREQ(NREQ), .DIV(DIV), .EN_PHASE(EN_PHASE)) dut (
        .clock(clock), .reset(reset), .req(req), .reqData(reqData), .ack(ack),
        .enable(enable), .shiftLoad(shiftLoad), .parallelOut(parallelOut),
        .txEmpty(txEmpty), .busy(busy), .grantId(grantId)
    );

    // UartXmt model: start, 8 data LSB-first, stop, then one more bit period before empty.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_empty <= 1'b1;
            txd         <= 1'b1;
            sh          <= '0;
            cnt         <= 0;
        end else if (enable && !shiftLoad) begin
            sh          <= {1'b1, parallelOut};
            txd         <= 1'b0;
            cnt         <= 9;
            model_empty <= 1'b0;
            line_q.push_back(0);
        end else if (enable && !model_empty) begin
            if (cnt > 0) begin
                txd <= sh[0];
                line_q.push_back(int'(sh[0]));
                sh  <= sh >> 1;
                cnt <= cnt - 1;
            end else begin
                model_empty <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) ack_total += $countones(ack);
    end

    function automatic int rr_pick(int ptr, logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req = '0;
        hold_low = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rr_model = NREQ - 1;
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a, output bit ok);
        a = '0;
        ok = 1'b0;
        for (int i = 0; i < 20*DIV; i++) begin
            @(negedge clock);
            if (ack != '0) begin
                a = ack;
                ok = 1'b1;
                line_q.delete();
                break;
            end
        end
    endtask

    task automatic wait_frame(output logic [9:0] bits, output bit ok);
        bit done = 1'b0;
        bits = '0;
        for (int i = 0; i < 14*DIV; i++) begin
            @(negedge clock);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        ok = done && (line_q.size() == 10);
        if (ok) for (int i = 0; i < 10; i++) bits[i] = line_q[i][0];
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (ack !== '0 || shiftLoad !== 1'b1 || parallelOut !== 8'h00 || busy !== 1'b0 ||
            grantId !== '0 || enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ack=%b shl=%b pout=%h busy=%b gid=%0d en=%b, want 0 1 00 0 0 0",
                     ack, shiftLoad, parallelOut, busy, grantId, enable);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 3*DIV; k++) begin
            checks++;
            if (enable !== ((k % DIV) == ((EN_PHASE + 1) % DIV))) begin
                errors++;
                $display("FAIL enable_edge%0d: got %b want %b", k, enable, ((k % DIV) == ((EN_PHASE + 1) % DIV)));
            end
            @(negedge clock);
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] a;
        logic [9:0] bits;
        bit ok;
        int n;
        int base;
        do_reset();
        base = ack_total;
        reqData[7:0] = 8'hA5;
        req = 4'b0001;
        wait_ack(a, ok);
        checks++;
        if (!ok || a !== 4'b0001 || grantId !== 2'd0 || parallelOut !== 8'hA5 || busy !== 1'b1 || shiftLoad !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: ok=%0d ack=%b gid=%0d pout=%h busy=%b shl=%b want 0001 0 a5 1 0",
                     ok, a, grantId, parallelOut, busy, shiftLoad);
        end
        @(negedge clock);
        req = '0;
        checks++;
        if (ack !== '0) begin
            errors++;
            $display("FAIL ack_pulse_width: ack=%b want 0000", ack);
        end
        n = 1;
        while (!shiftLoad && n < DIV + 2) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n < 1 || n > DIV || shiftLoad !== 1'b1) begin
            errors++;
            $display("FAIL load_latency: got %0d cycles want 1..%0d", n, DIV);
        end
        wait_frame(bits, ok);
        checks++;
        if (!ok || bits !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL single_frame: ok=%0d bits=%b want %b", ok, bits, {1'b1, 8'hA5, 1'b0});
        end
        checks++;
        if (ack_total - base !== 1 || parallelOut !== 8'hA5) begin
            errors++;
            $display("FAIL single_ack_count: acks=%0d pout=%h want 1 a5", ack_total - base, parallelOut);
        end
    endtask

    task automatic test_all_four();
        logic [NREQ-1:0] a;
        logic [9:0] bits;
        logic [7:0] b;
        bit ok;
        int base;
        do_reset();
        base = ack_total;
        reqData = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            b = reqData[8*g +: 8];
            wait_ack(a, ok);
            if (g == 3) req = '0;
            checks++;
            if (!ok || a !== 4'(1 << g) || grantId !== 2'(g) || parallelOut !== b) begin
                errors++;
                $display("FAIL rr_grant%0d: ok=%0d ack=%b gid=%0d pout=%h want %b %0d %h",
                         g, ok, a, grantId, parallelOut, 4'(1 << g), g, b);
            end
            wait_frame(bits, ok);
            checks++;
            if (!ok || bits !== {1'b1, b, 1'b0}) begin
                errors++;
                $display("FAIL rr_frame%0d: ok=%0d bits=%b want %b", g, ok, bits, {1'b1, b, 1'b0});
            end
        end
        repeat (2*DIV) @(negedge clock);
        checks++;
        if (ack_total - base !== 4) begin
            errors++;
            $display("FAIL rr_ack_count: got %0d want 4", ack_total - base);
        end
    endtask

    task automatic test_alternate();
        logic [NREQ-1:0] a;
        logic [9:0] bits;
        bit ok;
        int seq[4] = '{1, 3, 1, 3};
        do_reset();
        reqData = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req = 4'b0010;
        for (int s = 0; s < 4; s++) begin
            wait_ack(a, ok);
            req = (s == 3) ? 4'b0000 : 4'b1010;
            checks++;
            if (!ok || a !== 4'(1 << seq[s]) || grantId !== 2'(seq[s])) begin
                errors++;
                $display("FAIL alt_grant%0d: ok=%0d ack=%b gid=%0d want %b %0d",
                         s, ok, a, grantId, 4'(1 << seq[s]), seq[s]);
            end
            wait_frame(bits, ok);
        end
    endtask

    task automatic test_txempty_block();
        logic [NREQ-1:0] a;
        logic [9:0] bits;
        bit ok;
        int base;
        do_reset();
        reqData[23:16] = 8'h6E;
        hold_low = 1'b1;
        req = 4'b0100;
        base = ack_total;
        repeat (3*DIV) @(negedge clock);
        checks++;
        if (ack_total !== base || busy !== 1'b0) begin
            errors++;
            $display("FAIL txempty_block: acks=%0d busy=%b want 0 0", ack_total - base, busy);
        end
        hold_low = 1'b0;
        @(negedge clock);
        a = ack;
        checks++;
        if (a !== 4'b0100) begin
            errors++;
            $display("FAIL txempty_release: ack=%b want 0100", a);
        end
        req = '0;
        line_q.delete();
        wait_frame(bits, ok);
        checks++;
        if (!ok || bits !== {1'b1, 8'h6E, 1'b0}) begin
            errors++;
            $display("FAIL txempty_frame: ok=%0d bits=%b want %b", ok, bits, {1'b1, 8'h6E, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] a;
        logic [9:0] bits;
        bit ok;
        int n;
        do_reset();
        reqData[7:0] = 8'h3C;
        req = 4'b0100;
        reqData[23:16] = 8'h77;
        wait_ack(a, ok);
        req = '0;
        n = 0;
        while (!shiftLoad && n < DIV + 2) begin
            @(negedge clock);
            n++;
        end
        repeat (3*DIV) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || shiftLoad !== 1'b1 || grantId !== 2'd2) begin
            errors++;
            $display("FAIL mid_send_state: busy=%b shl=%b gid=%0d want 1 1 2", busy, shiftLoad, grantId);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (shiftLoad !== 1'b1 || busy !== 1'b0 || ack !== '0 || enable !== 1'b0 ||
            parallelOut !== 8'h00 || grantId !== '0) begin
            errors++;
            $display("FAIL mid_reset: shl=%b busy=%b ack=%b en=%b pout=%h gid=%0d want 1 0 0000 0 00 0",
                     shiftLoad, busy, ack, enable, parallelOut, grantId);
        end
        @(negedge clock);
        reset = 1'b0;
        reqData[7:0] = 8'h5A;
        reqData[31:24] = 8'hC3;
        req = 4'b1001;
        wait_ack(a, ok);
        req = '0;
        checks++;
        if (!ok || a !== 4'b0001 || grantId !== 2'd0 || parallelOut !== 8'h5A) begin
            errors++;
            $display("FAIL post_reset_grant: ok=%0d ack=%b gid=%0d pout=%h want 0001 0 5a",
                     ok, a, grantId, parallelOut);
        end
        wait_frame(bits, ok);
        checks++;
        if (!ok || bits !== {1'b1, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_frame: ok=%0d bits=%b want %b", ok, bits, {1'b1, 8'h5A, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] a;
        logic [9:0] bits;
        logic [7:0] b;
        bit ok;
        int w;
        do_reset();
        req = 4'($urandom_range(1, 15));
        reqData = {$urandom(), $urandom()};
        for (int it = 0; it < 25; it++) begin
            w = rr_pick(rr_model, req);
            b = reqData[8*w +: 8];
            wait_ack(a, ok);
            checks++;
            if (!ok || a !== 4'(1 << w) || grantId !== 2'(w) || parallelOut !== b) begin
                errors++;
                $display("FAIL rand_grant%0d: ok=%0d ack=%b gid=%0d pout=%h want %b %0d %h",
                         it, ok, a, grantId, parallelOut, 4'(1 << w), w, b);
            end
            rr_model = w;
            req = (it == 24) ? 4'b0000 : 4'($urandom_range(1, 15));
            reqData = {$urandom(), $urandom()};
            wait_frame(bits, ok);
            checks++;
            if (!ok || bits !== {1'b1, b, 1'b0}) begin
                errors++;
                $display("FAIL rand_frame%0d: ok=%0d bits=%b want %b", it, ok, bits, {1'b1, b, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_txempty_block();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
